// File: rtl/clock_pattern_detector.sv
// RX-side MB clock-training pattern detector: locks onto the 1,1,0 gate pattern and
// checks it for NUM_CHECK_CYCLES cycles. Optional WAIT_LOCK timeout: CLK_PATTERN_DET_TIMEOUT_EN.
module clock_pattern_detector #(
    parameter int NUM_CHECK_CYCLES = 180,
    parameter int ERR_THRESHOLD    = 2,
    parameter int LOCK_TIMEOUT     = 64
) (
    input  logic       i_dig_clk,
    input  logic       i_rst_n,
    input  logic       i_start_clk_detect,
    input  logic       i_ltsm_in_reset,
    input  logic       i_clk_active,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_err_count,
    output logic       o_locked
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_CHECK     = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam int         CNT_W      = (NUM_CHECK_CYCLES > 1) ? $clog2(NUM_CHECK_CYCLES) : 1;
    localparam int         TMO_W      = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [7:0] LP_ERR_THR = 8'(ERR_THRESHOLD);

`ifdef CLK_PATTERN_DET_TIMEOUT_EN
    localparam bit LP_TMO_EN = 1'b1;
`else
    localparam bit LP_TMO_EN = 1'b0;
`endif

    logic [1:0]       r_state;
    logic [1:0]       r_hist;
    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_cyc;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_err;
    logic             r_done;
    logic             r_pass;
    logic             r_locked;

    logic [2:0] w_window;
    logic       w_lock_hit;
    logic       w_expected;
    logic       w_mismatch;
    logic [7:0] w_err_inc;
    logic [7:0] w_err_next;
    logic       w_last_check;
    logic       w_timeout;
    logic       w_abort;

    // The two stored samples plus the live one form the 3-sample window, so lock lands
    // on the edge that captures the idle slot and CHECK phase 0 is the next active slot.
    assign w_window     = {r_hist, i_clk_active};
    assign w_lock_hit   = (w_window == 3'b110);
    assign w_expected   = (r_phase != 2'd2);
    assign w_mismatch   = (i_clk_active != w_expected);
    assign w_err_inc    = (r_err == 8'hFF) ? r_err : (r_err + 8'd1);
    assign w_err_next   = w_mismatch ? w_err_inc : r_err;
    assign w_last_check = (r_cyc == CNT_W'(NUM_CHECK_CYCLES - 1));
    assign w_timeout    = LP_TMO_EN && (r_tmo == TMO_W'(LOCK_TIMEOUT - 1));
    assign w_abort      = i_ltsm_in_reset || !i_start_clk_detect;

    always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_hist   <= 2'b00;
            r_phase  <= 2'd0;
            r_cyc    <= '0;
            r_tmo    <= '0;
            r_err    <= 8'd0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_locked <= 1'b0;
        end else if (w_abort) begin
            // LTSM reset or a dropped request wins over everything, even the final check cycle.
            r_state  <= ST_IDLE;
            r_hist   <= 2'b00;
            r_phase  <= 2'd0;
            r_cyc    <= '0;
            r_tmo    <= '0;
            r_err    <= 8'd0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_WAIT_LOCK;
                    r_hist   <= 2'b00;
                    r_phase  <= 2'd0;
                    r_cyc    <= '0;
                    r_tmo    <= '0;
                    r_err    <= 8'd0;
                    r_done   <= 1'b0;
                    r_pass   <= 1'b0;
                    r_locked <= 1'b0;
                end
                ST_WAIT_LOCK: begin
                    r_hist <= w_window[1:0];
                    r_tmo  <= r_tmo + TMO_W'(1);
                    if (w_lock_hit) begin
                        r_state  <= ST_CHECK;
                        r_locked <= 1'b1;
                        r_phase  <= 2'd0;
                        r_cyc    <= '0;
                    end else if (w_timeout) begin
                        r_state  <= ST_DONE;
                        r_err    <= 8'hFF;
                        r_pass   <= 1'b0;
                        r_locked <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_err   <= w_err_next;
                    r_phase <= (r_phase == 2'd2) ? 2'd0 : (r_phase + 2'd1);
                    r_cyc   <= r_cyc + CNT_W'(1);
                    if (w_last_check) begin
                        r_state <= ST_DONE;
                        r_pass  <= (w_err_next <= LP_ERR_THR);
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err;
    assign o_locked    = r_locked;

endmodule

// File: tb/tb_clock_pattern_detector.sv
// Scoreboard bench for clock_pattern_detector: a sample-array model predicts lock and
// done cycles, error count and pass; a negedge monitor pops and compares on output edges.
module tb_clock_pattern_detector;

    localparam int NCHK    = 180;
    localparam int THR     = 2;
    localparam int TIMEOUT = 64;

    typedef struct {
        int doneCycle;
        int err;
        int pass;
        int locked;
    } doneExp_t;

    logic       clk;
    logic       rstN;
    logic       iStart;
    logic       iLtsm;
    logic       iClkActive;
    logic       oDone;
    logic       oPass;
    logic [7:0] oErrCount;
    logic       oLocked;

    int       cycleCount = 0;
    int       checkCount = 0;
    int       errCount   = 0;
    bit       pat[$];
    int       lockQ[$];
    doneExp_t doneQ[$];
    logic     prevDone   = 1'b0;
    logic     prevLocked = 1'b0;

    clock_pattern_detector #(
        .NUM_CHECK_CYCLES(NCHK),
        .ERR_THRESHOLD   (THR),
        .LOCK_TIMEOUT    (TIMEOUT)
    ) dut (
        .i_dig_clk         (clk),
        .i_rst_n           (rstN),
        .i_start_clk_detect(iStart),
        .i_ltsm_in_reset   (iLtsm),
        .i_clk_active      (iClkActive),
        .o_done            (oDone),
        .o_pass            (oPass),
        .o_err_count       (oErrCount),
        .o_locked          (oLocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_done"}, int'(oDone), 0);
        checkOutput({name, "_pass"}, int'(oPass), 0);
        checkOutput({name, "_err"}, int'(oErrCount), 0);
        checkOutput({name, "_locked"}, int'(oLocked), 0);
    endtask

    // Reference: first index whose last three samples read 1,1,0 (history starts cleared).
    function automatic int findLock();
        for (int i = 2; i < pat.size(); i++)
            if (pat[i-2] == 1'b1 && pat[i-1] == 1'b1 && pat[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int countErrors(input int k);
        int e = 0;
        for (int m = 0; m < NCHK; m++) begin
            bit exp = ((m % 3) != 2);
            if (pat[k + 1 + m] != exp) e++;
        end
        return (e > 255) ? 255 : e;
    endfunction

    function automatic void addPeriods(input int n);
        for (int i = 0; i < n; i++) begin
            pat.push_back(1'b1);
            pat.push_back(1'b1);
            pat.push_back(1'b0);
        end
    endfunction

    // Monitor: compares whenever the DUT raises o_locked or o_done.
    always @(negedge clk) begin
        if (oLocked && !prevLocked) begin
            if (lockQ.size() == 0) checkOutput("unexpected_lock", 1, 0);
            else checkOutput("lock_cycle", cycleCount, lockQ.pop_front());
        end
        if (oDone && !prevDone) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                doneExp_t e;
                e = doneQ.pop_front();
                checkOutput("done_cycle", cycleCount, e.doneCycle);
                checkOutput("done_err", int'(oErrCount), e.err);
                checkOutput("done_pass", int'(oPass), e.pass);
                checkOutput("done_locked", int'(oLocked), e.locked);
            end
        end
        prevLocked = oLocked;
        prevDone   = oDone;
    end

    // abortKind: 0 run to DONE, 1 LTSM reset, 2 start dropped, 3 async reset; abortAt = check cycle.
    task automatic applyStimulus(input string name, input int abortKind, input int abortAt);
        int       k;
        int       base;
        int       lastIdx;
        doneExp_t e;
        k = findLock();
        @(negedge clk);
        iStart     = 1'b1;
        iLtsm      = 1'b0;
        iClkActive = 1'b0;
        @(negedge clk);
        base = cycleCount + 1;
        if (k >= 0) lockQ.push_back(base + k);
        if (abortKind == 0) begin
            if (k >= 0) begin
                e.doneCycle = base + k + NCHK + 1;
                e.err       = countErrors(k);
                e.pass      = (e.err <= THR) ? 1 : 0;
                e.locked    = 1;
            end else begin
                e.doneCycle = base + TIMEOUT;
                e.err       = 255;
                e.pass      = 0;
                e.locked    = 0;
            end
            doneQ.push_back(e);
        end
        lastIdx = (abortKind == 0) ? pat.size() - 1 : k + abortAt;
        for (int j = 0; j <= lastIdx; j++) begin
            iClkActive = pat[j];
            @(negedge clk);
        end
        case (abortKind)
            0: begin
                for (int h = 0; h < 20; h++) begin
                    checkOutput({name, "_done_hold"}, int'(oDone), 1);
                    @(negedge clk);
                end
                iStart = 1'b0;
                @(negedge clk);
                checkIdle({name, "_drop"});
            end
            1: begin
                iLtsm      = 1'b1;
                iClkActive = pat[lastIdx + 1];
                @(negedge clk);
                checkIdle({name, "_ltsm"});
                iLtsm  = 1'b0;
                iStart = 1'b0;
                @(negedge clk);
            end
            2: begin
                iStart = 1'b0;
                @(negedge clk);
                checkIdle({name, "_stop"});
            end
            default: begin
                #2 rstN = 1'b0;
                #1 checkIdle({name, "_arst"});
                @(negedge clk);
                rstN   = 1'b1;
                iStart = 1'b0;
                @(negedge clk);
            end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int pre;
        rstN       = 1'b0;
        iStart     = 1'b0;
        iLtsm      = 1'b0;
        iClkActive = 1'b0;
        repeat (2) @(negedge clk);
        checkIdle("reset");
        rstN = 1'b1;

        pat.delete(); pat.push_back(0); pat.push_back(0); addPeriods(62);
        applyStimulus("clean", 0, 0);

        pat.delete(); pat.push_back(0); pat.push_back(0); addPeriods(62);
        k = findLock();
        pat[k + 1 + 10]  = ~pat[k + 1 + 10];
        pat[k + 1 + 100] = ~pat[k + 1 + 100];
        applyStimulus("flip2", 0, 0);

        pat.delete(); pat.push_back(0); pat.push_back(0); addPeriods(62);
        k = findLock();
        pat[k + 1 + 10]  = ~pat[k + 1 + 10];
        pat[k + 1 + 100] = ~pat[k + 1 + 100];
        pat[k + 1 + 179] = ~pat[k + 1 + 179];
        applyStimulus("flip3", 0, 0);

        pat.delete(); pat.push_back(0); pat.push_back(0); addPeriods(1);
        repeat (183) pat.push_back(1'b1);
        applyStimulus("const1", 0, 0);

        pat.delete(); pat.push_back(0); pat.push_back(0); addPeriods(1);
        repeat (183) pat.push_back(1'b0);
        applyStimulus("const0", 0, 0);

        pat.delete(); pat.push_back(0); pat.push_back(0); addPeriods(62);
        applyStimulus("ltsm_abort", 1, 50);
        applyStimulus("restart", 0, 0);

        applyStimulus("start_abort", 2, 20);

        pat.delete(); pat.push_back(0); pat.push_back(0); addPeriods(1);
        repeat (183) pat.push_back(1'b1);
        applyStimulus("async_rst", 3, 30);

        for (int r = 0; r < 6; r++) begin
            pat.delete();
            pre = $urandom_range(3, 12);
            for (int i = 0; i < pre; i++) pat.push_back(1'($urandom_range(0, 1)));
            addPeriods(62);
            for (int i = pre + 3; i < pat.size(); i++)
                if ($urandom_range(0, 59) == 0) pat[i] = ~pat[i];
            applyStimulus($sformatf("rand%0d", r), 0, 0);
        end

`ifdef CLK_PATTERN_DET_TIMEOUT_EN
        pat.delete();
        repeat (80) pat.push_back(1'b0);
        applyStimulus("timeout", 0, 0);
`endif

        repeat (2) @(negedge clk);
        checkOutput("pending_lock", lockQ.size(), 0);
        checkOutput("pending_done", doneQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/clock_pattern_detector.md
Name: clock_pattern_detector

Overview:
- RX-side counterpart of the MB clock-training pattern generator.
- Monitors a per-i_dig_clk "forwarded clock active" sample and locks onto the training gate pattern.
- Checks the pattern for a fixed window and reports done/pass plus an error count to the LTSM.
- Sits in the MB clock RX path, between the forwarded-clock activity sampler and the LTSM.

Parameters:
- NUM_CHECK_CYCLES, 180, number of i_dig_clk cycles compared after lock (multiple of 3; 60 pattern periods).
- ERR_THRESHOLD, 2, maximum mismatches still reported as pass.
- LOCK_TIMEOUT, 64, cycles allowed in WAIT_LOCK before failing (used only with the optional feature).

Ports:
- i_dig_clk  input  1  digital clock (pll /32); sole clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start_clk_detect  input  1  level request from LTSM to start detection.
- i_ltsm_in_reset  input  1  LTSM in RESET; aborts detection.
- i_clk_active  input  1  1 = forwarded-clock edges seen during this i_dig_clk cycle.
- o_done  output  1  detection finished; held in DONE.
- o_pass  output  1  valid when o_done = 1; 1 = err count <= ERR_THRESHOLD and lock achieved.
- o_err_count  output  8  saturating mismatch count.
- o_locked  output  1  pattern phase acquired.

Behaviour:
- Single clock i_dig_clk; asynchronous active-low reset i_rst_n. All state and outputs are registered.
- Reset values: FSM = IDLE; o_done = 0, o_pass = 0, o_err_count = 0, o_locked = 0; phase and cycle counters = 0.
- Expected training pattern, period 3 cycles: active, active, idle (1,1,0).
- FSM states: IDLE, WAIT_LOCK, CHECK, DONE.
- IDLE:
  - Clears counters and outputs.
  - Moves to WAIT_LOCK when i_start_clk_detect = 1 and i_ltsm_in_reset = 0.
- WAIT_LOCK:
  - Shifts i_clk_active into a 3-bit history.
  - When the history equals 1,1,0 (oldest to newest), sets o_locked = 1 on the next edge.
  - On that same edge: enters CHECK, phase = 0, cycle counter = 0.
- CHECK, every cycle:
  - expected = (phase != 2).
  - If i_clk_active != expected, increment o_err_count, saturating at 255.
  - Phase wraps 0→1→2→0. Cycle counter increments.
  - When the cycle counter = NUM_CHECK_CYCLES-1, that cycle is still compared, then the FSM goes to DONE.
- DONE:
  - o_done = 1; o_pass = (o_err_count <= ERR_THRESHOLD). The final error count is included; the pass term is registered on the DONE entry edge.
  - Holds until i_start_clk_detect = 0 or i_ltsm_in_reset = 1, then returns to IDLE and clears all outputs.
- Latency: o_done rises exactly NUM_CHECK_CYCLES+1 cycles after the lock edge.
- Priority:
  - i_ltsm_in_reset = 1 in any state forces IDLE on the next edge, overriding all other conditions including the final CHECK cycle.
  - i_start_clk_detect deasserting in WAIT_LOCK or CHECK also forces IDLE; no o_done pulse is produced.
- Asynchronous reset mid-operation returns everything to reset values immediately.
- Once in CHECK, the block does not re-lock; phase slips appear as errors.

Optional Feature:
- Macro: CLK_PATTERN_DET_TIMEOUT_EN.
- Defined:
  - WAIT_LOCK counts cycles. When the count reaches LOCK_TIMEOUT without lock, the FSM goes to DONE.
  - In that case o_done = 1, o_pass = 0, o_locked = 0, o_err_count = 255.
  - The timeout counter clears on entering WAIT_LOCK.
- Not defined: WAIT_LOCK waits indefinitely; the LTSM-level timer covers the hang case.

Test Plan:
- Clean pattern: start = 1, drive 1,1,0 repeating → o_locked after the first 1,1,0; o_done = 1 exactly 181 cycles after the lock edge; o_pass = 1; o_err_count = 0.
- Two flipped samples at check cycles 10 and 100 → o_err_count = 2, o_pass = 1. Three flips → o_err_count = 3, o_pass = 0.
- Constant i_clk_active = 1 after lock → o_err_count = 60 (each idle slot wrong), o_pass = 0. Constant 0 → o_err_count = 120.
- i_ltsm_in_reset pulsed at check cycle 50 → IDLE next edge, all outputs 0; restart with a clean pattern → pass.
- i_rst_n asserted mid-CHECK → outputs 0 immediately. With CLK_PATTERN_DET_TIMEOUT_EN and all-zero input → o_done after 64 WAIT_LOCK cycles, o_pass = 0, o_err_count = 255.
- DONE hold: keep start = 1 for 20 cycles → o_done stays 1. Drop start → IDLE, o_done = 0 next cycle.
